// File: rtl/lif_neuron_if.sv
// Handshake and data bundle between the timestep sequencer (master) and the
// leaky-integrate-and-fire core (slave).
interface lif_neuron_if #(
    parameter int N_SYN = 16
);
    logic                   start;
    logic [N_SYN*32-1:0]    weights;
    logic [N_SYN*32-1:0]    spikes;
    logic [31:0]            vth;
    logic [31:0]            rpr;
    logic                   busy;
    logic                   done;
    logic                   spike_out;
    logic [31:0]            vmem;
    logic [31:0]            refr_cnt;

    modport master (
        output start, weights, spikes, vth, rpr,
        input  busy, done, spike_out, vmem, refr_cnt
    );

    modport slave (
        input  start, weights, spikes, vth, rpr,
        output busy, done, spike_out, vmem, refr_cnt
    );
endinterface

// File: rtl/lif_neuron_core.sv
// One leaky-integrate-and-fire timestep for a single neuron: serial weighted
// spike accumulation (one synapse per cycle), leak, threshold, refractory.
module lif_neuron_core #(
    parameter int N_SYN      = 16,
    parameter int LEAK_SHIFT = 4
) (
    input  logic            clk,
    input  logic            reset,
    lif_neuron_if.slave     bus
);
    localparam int IDX_W = (N_SYN > 1) ? $clog2(N_SYN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SYN - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Clamp a 34-bit signed intermediate into the signed 32-bit range.
    function automatic logic [31:0] sat32(input logic signed [33:0] x);
        if (x > 34'sh0_7FFF_FFFF) begin
            return 32'h7FFF_FFFF;
        end else if (x < 34'sh3_8000_0000) begin
            return 32'h8000_0000;
        end else begin
            return x[31:0];
        end
    endfunction

    logic [1:0]             state_q,  state_d;
    logic [IDX_W-1:0]       idx_q,    idx_d;
    logic signed [31:0]     acc_q,    acc_d;
    logic [N_SYN*32-1:0]    w_q,      w_d;
    logic [N_SYN-1:0]       act_q,    act_d;     // only bit 0 of each spike lane matters
    logic signed [31:0]     vth_q,    vth_d;
    logic [31:0]            rpr_q,    rpr_d;
    logic signed [31:0]     vmem_q,   vmem_d;
    logic [31:0]            refr_q,   refr_d;
    logic                   spike_q,  spike_d;
    logic                   busy_q,   busy_d;
    logic                   done_q,   done_d;

    logic signed [31:0]     w_lane_s;
    logic signed [31:0]     leak_s;
    logic signed [33:0]     acc_sum_s;
    logic signed [33:0]     v_sum_s;
    logic signed [31:0]     v_s;

    // Datapath: selected weight, saturating accumulate and leaky integrate.
    always_comb begin
        w_lane_s  = w_q[idx_q*32 +: 32];
        if (LEAK_SHIFT == 0) begin
            leak_s = 32'sd0;
        end else begin
            leak_s = vmem_q >>> LEAK_SHIFT;
        end
        acc_sum_s = {{2{acc_q[31]}}, acc_q} + {{2{w_lane_s[31]}}, w_lane_s};
        v_sum_s   = {{2{vmem_q[31]}}, vmem_q} - {{2{leak_s[31]}}, leak_s}
                  + {{2{acc_q[31]}}, acc_q};
        v_s       = sat32(v_sum_s);
    end

    // Next-state logic for the IDLE -> ACCUM -> UPDATE -> DONE sequence.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        w_d     = w_q;
        act_d   = act_q;
        vth_d   = vth_q;
        rpr_d   = rpr_q;
        vmem_d  = vmem_q;
        refr_d  = refr_q;
        spike_d = spike_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    w_d = bus.weights;
                    for (int i = 0; i < N_SYN; i++) begin
                        act_d[i] = bus.spikes[i*32];
                    end
                    vth_d   = bus.vth;
                    rpr_d   = bus.rpr;
                    acc_d   = 32'sd0;
                    idx_d   = '0;
                    spike_d = 1'b0;
                    state_d = S_ACCUM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (act_q[idx_q]) begin
                    acc_d = sat32(acc_sum_s);
                end else begin
                    acc_d = acc_q;
                end
                if (idx_q == IDX_LAST) begin
                    state_d = S_UPDATE;
                end else begin
                    idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
            S_UPDATE: begin
                // A refractory neuron ignores this timestep's input entirely.
                if (refr_q != 32'd0) begin
                    refr_d  = refr_q - 32'd1;
                    vmem_d  = 32'sd0;
                    spike_d = 1'b0;
                end else if (v_s >= vth_q) begin
                    spike_d = 1'b1;
                    vmem_d  = 32'sd0;
                    refr_d  = rpr_q;
                end else begin
                    spike_d = 1'b0;
                    vmem_d  = v_s;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers; reset wins over any activity.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            acc_q   <= 32'sd0;
            w_q     <= '0;
            act_q   <= '0;
            vth_q   <= 32'sd0;
            rpr_q   <= 32'd0;
            vmem_q  <= 32'sd0;
            refr_q  <= 32'd0;
            spike_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            w_q     <= w_d;
            act_q   <= act_d;
            vth_q   <= vth_d;
            rpr_q   <= rpr_d;
            vmem_q  <= vmem_d;
            refr_q  <= refr_d;
            spike_q <= spike_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.spike_out = spike_q;
    assign bus.vmem      = vmem_q;
    assign bus.refr_cnt  = refr_q;
endmodule
